// File: rtl/pito_loader_pkg.sv
// rtl/pito_loader_pkg.sv - shared state type and width defaults for the pito imem loader
package pito_loader_pkg;

    localparam int LOADER_ADDR_W = 12;
    localparam int LOADER_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_VERIFY,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/pito_loader_sum.sv
// rtl/pito_loader_sum.sv - modular accumulator with clear and enable
module pito_loader_sum
    import pito_loader_pkg::*;
#(
    parameter int DATA_W = LOADER_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/pito_imem_loader.sv
// rtl/pito_imem_loader.sv - streams host words into imem, reads them back and checks the sum
module pito_imem_loader
    import pito_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic              imem_we,
    output logic              imem_re,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              core_hold
);

    localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state, state_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   widx;
    logic [ADDR_W:0]   ridx;
    logic              rvalid;
    logic [DATA_W-1:0] wsum;
    logic [DATA_W-1:0] rsum;
    logic [DATA_W-1:0] rsum_final;
    logic [ADDR_W+1:0] range_end;
    logic              start_seen;
    logic              range_bad;
    logic              hs;
    logic              last_write;
    logic              rd_issue;
    logic              last_read;
    logic              mismatch;

    // Two extra bits so base + len can be compared against the memory size without wrapping.
    assign range_end  = {2'b00, ld_base} + {1'b0, ld_len};
    assign range_bad  = range_end > MEM_WORDS;
    assign start_seen = (state == ST_IDLE) && ld_start;

    assign ld_ready   = !rst && (state == ST_LOAD) && (widx < len);
    assign hs         = ld_valid && ld_ready;
    assign last_write = hs && ((widx + IDX_ONE) == len);

    // The first read leaves from DRAIN so it lands on the bus the cycle after the last write.
    assign rd_issue   = (state == ST_DRAIN) || ((state == ST_VERIFY) && (ridx < len));
    assign last_read  = (state == ST_VERIFY) && rvalid && !imem_re;
    assign rsum_final = rsum + imem_rdata;
    assign mismatch   = rsum_final != wsum;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ld_start && !range_bad) begin
                    state_next = (ld_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:   if (last_write) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_VERIFY;
            ST_VERIFY: if (last_read) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base   <= '0;
            len    <= '0;
            widx   <= '0;
            ridx   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= imem_re;
            if (start_seen) begin
                base <= ld_base;
                len  <= ld_len;
                widx <= '0;
                ridx <= '0;
            end
            if (hs) begin
                widx <= widx + IDX_ONE;
            end
            if (rd_issue) begin
                ridx <= ridx + IDX_ONE;
            end
        end
    end

    pito_loader_sum #(.DATA_W(DATA_W)) u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (start_seen),
        .en  (hs),
        .din (ld_data),
        .sum (wsum)
    );

    pito_loader_sum #(.DATA_W(DATA_W)) u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (start_seen),
        .en  (rvalid),
        .din (imem_rdata),
        .sum (rsum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_busy    <= 1'b0;
            ld_done    <= 1'b0;
            ld_err     <= 1'b0;
            imem_we    <= 1'b0;
            imem_re    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
        end else begin
            ld_busy <= (state_next != ST_IDLE);
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            imem_we <= 1'b0;
            imem_re <= 1'b0;
            if (start_seen && range_bad) begin
                ld_err <= 1'b1;
            end
            if (start_seen && !range_bad) begin
                if (ld_len == '0) begin
                    ld_done   <= 1'b1;
                    core_hold <= 1'b0;
                end else begin
                    core_hold <= 1'b1;
                end
            end
            if (hs) begin
                imem_we    <= 1'b1;
                imem_addr  <= base + widx[ADDR_W-1:0];
                imem_wdata <= ld_data;
            end
            if (rd_issue) begin
                imem_re   <= 1'b1;
                imem_addr <= base + ridx[ADDR_W-1:0];
            end
            // The final read word is folded in here rather than waiting a cycle for rsum.
            if (last_read) begin
                ld_done   <= 1'b1;
                ld_err    <= mismatch;
                core_hold <= mismatch;
            end
        end
    end

endmodule

// File: tb/tb_pito_imem_loader.sv
// tb/tb_pito_imem_loader.sv - randomized self-checking bench for pito_imem_loader
module tb_pito_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic [11:0] ld_base;
    logic [12:0] ld_len;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic        imem_we;
    logic        imem_re;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        core_hold;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mem [0:4095];
    logic        corrupt_en;
    logic [11:0] corrupt_addr;

    logic [31:0] wq [$];
    logic [11:0] wa_q [$];
    logic [31:0] wd_q [$];
    int          wc_q [$];
    logic [11:0] ra_q [$];
    int          rc_q [$];
    logic        vld_tr [0:127];
    logic        busy_tr [0:127];
    logic        hold_tr [0:127];
    int          done_c, err_c, n_done, n_err, run_cyc;

    always #5 clk = ~clk;

    pito_imem_loader #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_len     (ld_len),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .imem_we    (imem_we),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .core_hold  (core_hold)
    );

    // imem model: one-cycle read latency, optional +1 corruption at one address
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (imem_re) imem_rdata <= mem[imem_addr] + ((corrupt_en && imem_addr == corrupt_addr) ? 32'd1 : 32'd0);
    end

    // Cycle 0 carries ld_start; each later cycle is sampled 2 time units after its rising edge.
    task automatic run_load(input logic [11:0] b, input logic [12:0] n, input int mode, input int ncyc);
        int   sent;
        logic v;
        sent = 0;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
        done_c = -1; err_c = -1; n_done = 0; n_err = 0; run_cyc = ncyc;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            ld_start = (c == 0);
            ld_base = b;
            ld_len = n;
            if (c == 0) v = 1'b0;
            else if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (c % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            ld_valid = v;
            ld_data = (sent < wq.size()) ? wq[sent] : $urandom;
            #1;
            vld_tr[c] = v;
            busy_tr[c] = ld_busy;
            hold_tr[c] = core_hold;
            if (imem_we) begin wa_q.push_back(imem_addr); wd_q.push_back(imem_wdata); wc_q.push_back(c); end
            if (imem_re) begin ra_q.push_back(imem_addr); rc_q.push_back(c); end
            if (ld_done) begin n_done++; if (done_c < 0) done_c = c; end
            if (ld_err) begin n_err++; if (err_c < 0) err_c = c; end
            if (v && ld_ready) sent++;
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
    endtask

    // Reference timing: handshakes from cycle 1 while fewer than n accepted; done = last handshake + n + 3.
    function automatic int model_done(input int n);
        int acc, h;
        acc = 0; h = 0;
        if (n == 0) return 1;
        for (int c = 1; c < run_cyc && acc < n; c++) begin
            if (vld_tr[c]) begin acc++; h = c; end
        end
        return h + n + 3;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({ld_ready, ld_busy, ld_done, ld_err, imem_we, imem_re} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {ld_ready, ld_busy, ld_done, ld_err, imem_we, imem_re}); else n_pass++;
        n_total++; if (imem_addr !== 12'h0 || imem_wdata !== 32'h0) $display("FAIL reset_bus: got %h/%h want 000/00000000", imem_addr, imem_wdata); else n_pass++;
        n_total++; if (core_hold !== 1'b1) $display("FAIL reset_hold: got %b want 1", core_hold); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic(input string tag);
        wq = {32'h1, 32'h2, 32'h3, 32'h4};
        corrupt_en = 1'b0;
        run_load(12'h010, 13'd4, 0, 20);
        n_total++; if (wa_q.size() != 4) $display("FAIL %s_wr_count: got %0d want 4", tag, wa_q.size()); else n_pass++;
        for (int i = 0; i < wa_q.size(); i++) begin
            n_total++;
            if (wa_q[i] !== 12'h010 + 12'(i) || wd_q[i] !== wq[i] || wc_q[i] != i + 2)
                $display("FAIL %s_wr%0d: got %h/%h@%0d want %h/%h@%0d", tag, i, wa_q[i], wd_q[i], wc_q[i], 12'h010 + 12'(i), wq[i], i + 2);
            else n_pass++;
        end
        n_total++; if (ra_q.size() != 4) $display("FAIL %s_rd_count: got %0d want 4", tag, ra_q.size()); else n_pass++;
        for (int i = 0; i < ra_q.size(); i++) begin
            n_total++;
            if (ra_q[i] !== 12'h010 + 12'(i) || rc_q[i] != i + 6)
                $display("FAIL %s_rd%0d: got %h@%0d want %h@%0d", tag, i, ra_q[i], rc_q[i], 12'h010 + 12'(i), i + 6);
            else n_pass++;
        end
        n_total++; if (done_c != 11 || done_c != model_done(4)) $display("FAIL %s_done_cycle: got %0d want 11", tag, done_c); else n_pass++;
        n_total++; if (n_err != 0 || n_done != 1) $display("FAIL %s_pulses: got done=%0d err=%0d want 1/0", tag, n_done, n_err); else n_pass++;
        n_total++; if (hold_tr[12] !== 1'b0) $display("FAIL %s_hold: got %b want 0", tag, hold_tr[12]); else n_pass++;
        n_total++; if (busy_tr[1] !== 1'b1 || busy_tr[11] !== 1'b1 || busy_tr[12] !== 1'b0)
            $display("FAIL %s_busy: got %b%b%b want 110", tag, busy_tr[1], busy_tr[11], busy_tr[12]); else n_pass++;
    endtask

    task automatic test_stall();
        wq = {32'h1, 32'h2, 32'h3, 32'h4};
        corrupt_en = 1'b0;
        run_load(12'h010, 13'd4, 1, 20);
        n_total++; if (wa_q.size() != 4) $display("FAIL stall_wr_count: got %0d want 4", wa_q.size()); else n_pass++;
        for (int i = 0; i < wa_q.size(); i++) begin
            n_total++;
            if (wa_q[i] !== 12'h010 + 12'(i) || wd_q[i] !== wq[i])
                $display("FAIL stall_wr%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i], 12'h010 + 12'(i), wq[i]);
            else n_pass++;
        end
        n_total++; if (done_c != 15 || done_c != model_done(4)) $display("FAIL stall_done_cycle: got %0d want 15", done_c); else n_pass++;
        n_total++; if (n_err != 0) $display("FAIL stall_err: got %0d want 0", n_err); else n_pass++;
    endtask

    task automatic test_corrupt();
        wq = {32'h1, 32'h2, 32'h3, 32'h4};
        corrupt_en = 1'b1;
        corrupt_addr = 12'h012;
        run_load(12'h010, 13'd4, 0, 20);
        corrupt_en = 1'b0;
        n_total++; if (done_c != 11) $display("FAIL corrupt_done_cycle: got %0d want 11", done_c); else n_pass++;
        n_total++; if (err_c != 11 || n_err != 1) $display("FAIL corrupt_err: got %0d@%0d want 1@11", n_err, err_c); else n_pass++;
        n_total++; if (hold_tr[11] !== 1'b1 || hold_tr[12] !== 1'b1) $display("FAIL corrupt_hold: got %b%b want 11", hold_tr[11], hold_tr[12]); else n_pass++;
    endtask

    task automatic test_zero_len();
        wq.delete();
        run_load(12'h020, 13'd0, 0, 8);
        n_total++; if (done_c != 1 || n_done != 1) $display("FAIL zero_done: got %0d@%0d want 1@1", n_done, done_c); else n_pass++;
        n_total++; if (wa_q.size() != 0 || ra_q.size() != 0) $display("FAIL zero_traffic: got %0d/%0d want 0/0", wa_q.size(), ra_q.size()); else n_pass++;
        n_total++; if (n_err != 0) $display("FAIL zero_err: got %0d want 0", n_err); else n_pass++;
        n_total++; if (busy_tr[1] !== 1'b1 || busy_tr[2] !== 1'b0) $display("FAIL zero_busy: got %b%b want 10", busy_tr[1], busy_tr[2]); else n_pass++;
        n_total++; if (hold_tr[2] !== 1'b0) $display("FAIL zero_hold: got %b want 0", hold_tr[2]); else n_pass++;
    endtask

    task automatic test_range();
        logic hold_before;
        int   busy_cnt;
        hold_before = core_hold;
        wq = {32'hdeadbeef, 32'h12345678, 32'h0badf00d};
        run_load(12'hffe, 13'd3, 0, 8);
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) if (busy_tr[c] !== 1'b0) busy_cnt++;
        n_total++; if (err_c != 1 || n_err != 1) $display("FAIL range_err: got %0d@%0d want 1@1", n_err, err_c); else n_pass++;
        n_total++; if (n_done != 0) $display("FAIL range_done: got %0d want 0", n_done); else n_pass++;
        n_total++; if (wa_q.size() != 0 || ra_q.size() != 0) $display("FAIL range_traffic: got %0d/%0d want 0/0", wa_q.size(), ra_q.size()); else n_pass++;
        n_total++; if (busy_cnt != 0) $display("FAIL range_busy: got %0d busy cycles want 0", busy_cnt); else n_pass++;
        n_total++; if (hold_tr[7] !== hold_before) $display("FAIL range_hold: got %b want %b", hold_tr[7], hold_before); else n_pass++;
    endtask

    task automatic test_reset_mid();
        wq = {32'haaaa0001, 32'haaaa0002, 32'haaaa0003, 32'haaaa0004};
        @(posedge clk); #1;
        ld_start = 1'b1; ld_base = 12'h040; ld_len = 13'd4; ld_valid = 1'b0;
        @(posedge clk); #1;
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = wq[0];
        @(posedge clk); #1;
        ld_data = wq[1];
        @(posedge clk); #1;
        rst = 1'b1; ld_data = wq[2];
        #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", ld_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; ld_valid = 1'b0;
        n_total++; if ({ld_ready, ld_busy, ld_done, ld_err, imem_we, imem_re} !== 6'b0) $display("FAIL midrst_flags: got %b want 000000", {ld_ready, ld_busy, ld_done, ld_err, imem_we, imem_re}); else n_pass++;
        n_total++; if (imem_addr !== 12'h0 || imem_wdata !== 32'h0) $display("FAIL midrst_bus: got %h/%h want 000/00000000", imem_addr, imem_wdata); else n_pass++;
        n_total++; if (core_hold !== 1'b1) $display("FAIL midrst_hold: got %b want 1", core_hold); else n_pass++;
        test_basic("after_rst");
    endtask

    task automatic test_random();
        int          n, exp_done;
        logic [11:0] b;
        logic [31:0] s_w, s_r;
        logic        exp_err;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 8);
            b = 12'($urandom_range(0, 4096 - n));
            wq.delete();
            s_w = 32'h0;
            for (int i = 0; i < n; i++) begin
                wq.push_back($urandom);
                s_w = s_w + wq[i];
            end
            corrupt_en = 1'($urandom_range(0, 1));
            corrupt_addr = b + 12'($urandom_range(0, n - 1));
            s_r = s_w + (corrupt_en ? 32'd1 : 32'd0);
            exp_err = (s_r != s_w);
            run_load(b, 13'(n), 2, 100);
            corrupt_en = 1'b0;
            exp_done = model_done(n);
            n_total++; if (wa_q.size() != n || ra_q.size() != n) $display("FAIL rand%0d_counts: got %0d/%0d want %0d", it, wa_q.size(), ra_q.size(), n); else n_pass++;
            for (int i = 0; i < wa_q.size() && i < n; i++) begin
                n_total++;
                if (wa_q[i] !== b + 12'(i) || wd_q[i] !== wq[i])
                    $display("FAIL rand%0d_wr%0d: got %h/%h want %h/%h", it, i, wa_q[i], wd_q[i], b + 12'(i), wq[i]);
                else n_pass++;
            end
            for (int i = 0; i < ra_q.size() && i < n; i++) begin
                n_total++;
                if (ra_q[i] !== b + 12'(i)) $display("FAIL rand%0d_rd%0d: got %h want %h", it, i, ra_q[i], b + 12'(i)); else n_pass++;
            end
            n_total++; if (done_c != exp_done) $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, done_c, exp_done); else n_pass++;
            n_total++; if ((n_err != 0) !== exp_err) $display("FAIL rand%0d_err: got %0d want %b", it, n_err, exp_err); else n_pass++;
            if (exp_done + 1 < run_cyc) begin
                n_total++; if (hold_tr[exp_done + 1] !== exp_err) $display("FAIL rand%0d_hold: got %b want %b", it, hold_tr[exp_done + 1], exp_err); else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ld_start = 1'b0;
        ld_base = 12'h0;
        ld_len = 13'h0;
        ld_data = 32'h0;
        ld_valid = 1'b0;
        corrupt_en = 1'b0;
        corrupt_addr = 12'h0;
        test_reset();
        test_basic("basic");
        test_stall();
        test_corrupt();
        test_zero_len();
        test_range();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
